// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C target receiver.
package i2c_pkg;

    localparam int   I2C_ADDR_W      = 7;
    localparam int   I2C_FRAME_BYTES = 2;
    localparam logic I2C_RD          = 1'b1;
    localparam logic I2C_WR          = 1'b0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_A_ACK,
        ST_WR_BYTE,
        ST_W_ACK,
        ST_RD_BYTE,
        ST_M_ACK,
        ST_WAIT_STOP
    } state_t;

    // True when the byte index names the final byte of a fixed-length frame.
    function automatic logic is_last_byte(input logic byte_idx);
        return int'(byte_idx) == I2C_FRAME_BYTES - 1;
    endfunction

endpackage

// File: rtl/i2c_line_sync.sv
// Two-flop synchroniser with optional stability filter (I2C_SLV_FILT_EN) and edge outputs.
module i2c_line_sync #(
    parameter int FILT_LEN = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic lvl,
    output logic rise,
    output logic fall
);

    logic ff1;
    logic ff2;
    logic prev;

    if (FILT_LEN < 1) begin : g_bad_filt
        $error("i2c_line_sync: FILT_LEN must be at least 1");
    end

    // Idle bus level is high, so flops reset to 1 to avoid a fake edge after reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            ff1 <= 1'b1;
            ff2 <= 1'b1;
        end else begin
            ff1 <= din;
            ff2 <= ff1;
        end
    end

`ifdef I2C_SLV_FILT_EN
    localparam int CNT_W = $clog2(FILT_LEN + 1);

    logic [CNT_W-1:0] cnt;
    logic             filt;

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt  <= '0;
            filt <= 1'b1;
        end else if (ff2 == filt) begin
            cnt <= '0;
        end else if (cnt == CNT_W'(FILT_LEN - 1)) begin
            filt <= ff2;
            cnt  <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign lvl = filt;
`else
    assign lvl = ff2;
`endif

    always_ff @(posedge clk) begin
        if (!rst) prev <= 1'b1;
        else      prev <= lvl;
    end

    assign rise = lvl & ~prev;
    assign fall = ~lvl & prev;

endmodule

// File: rtl/i2c_slave_rx.sv
// I2C target with fixed 2-byte write and read frames; optional input glitch filter via I2C_SLV_FILT_EN.
module i2c_slave_rx
    import i2c_pkg::*;
#(
    parameter logic [I2C_ADDR_W-1:0] SLV_ADDR = 7'h27,
    parameter int                    FILT_LEN = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sclk,
    inout  wire         sda,
    input  logic [15:0] rd_data,
    output logic        rd_req,
    output logic [15:0] wr_data,
    output logic        wr_valid,
    output logic        busy,
    output logic        nack_addr
);

    logic scl_s, scl_rise, scl_fall;
    logic sda_s, sda_rise, sda_fall;

    i2c_line_sync #(.FILT_LEN(FILT_LEN)) u_scl_sync (
        .clk  (clk),
        .rst  (rst),
        .din  (sclk),
        .lvl  (scl_s),
        .rise (scl_rise),
        .fall (scl_fall)
    );

    i2c_line_sync #(.FILT_LEN(FILT_LEN)) u_sda_sync (
        .clk  (clk),
        .rst  (rst),
        .din  (sda),
        .lvl  (sda_s),
        .rise (sda_rise),
        .fall (sda_fall)
    );

    logic start_det;
    logic stop_det;

    assign start_det = sda_fall & scl_s;
    assign stop_det  = sda_rise & scl_s;

    state_t      state_q,     state_d;
    logic [3:0]  bit_cnt_q,   bit_cnt_d;
    logic [15:0] shreg_q,     shreg_d;
    logic        byte_idx_q,  byte_idx_d;
    logic        rw_q,        rw_d;
    logic        sda_oe_q,    sda_oe_d;
    logic [15:0] wr_data_q,   wr_data_d;
    logic        wr_valid_q,  wr_valid_d;
    logic        rd_req_q,    rd_req_d;
    logic        nack_q,      nack_d;
    logic        busy_q,      busy_d;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            bit_cnt_q  <= '0;
            shreg_q    <= '0;
            byte_idx_q <= 1'b0;
            rw_q       <= I2C_WR;
            sda_oe_q   <= 1'b0;
            wr_data_q  <= '0;
            wr_valid_q <= 1'b0;
            rd_req_q   <= 1'b0;
            nack_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shreg_q    <= shreg_d;
            byte_idx_q <= byte_idx_d;
            rw_q       <= rw_d;
            sda_oe_q   <= sda_oe_d;
            wr_data_q  <= wr_data_d;
            wr_valid_q <= wr_valid_d;
            rd_req_q   <= rd_req_d;
            nack_q     <= nack_d;
            busy_q     <= busy_d;
        end
    end

    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned and infers a latch.
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shreg_d    = shreg_q;
        byte_idx_d = byte_idx_q;
        rw_d       = rw_q;
        sda_oe_d   = sda_oe_q;
        wr_data_d  = wr_data_q;
        wr_valid_d = 1'b0;
        rd_req_d   = 1'b0;
        nack_d     = 1'b0;
        busy_d     = busy_q;

        if (stop_det) begin
            state_d   = ST_IDLE;
            bit_cnt_d = '0;
            sda_oe_d  = 1'b0;
            busy_d    = 1'b0;
        end else if (start_det) begin
            state_d    = ST_ADDR;
            bit_cnt_d  = '0;
            byte_idx_d = 1'b0;
            sda_oe_d   = 1'b0;
            busy_d     = 1'b1;
        end else begin
            unique case (state_q)
                ST_IDLE: ;

                ST_ADDR: begin
                    if (scl_rise) begin
                        shreg_d   = {shreg_q[14:0], sda_s};
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end else if (scl_fall && bit_cnt_q == 4'd8) begin
                        bit_cnt_d = '0;
                        if (shreg_q[7:1] == SLV_ADDR) begin
                            rw_d     = shreg_q[0];
                            sda_oe_d = 1'b1;
                            state_d  = ST_A_ACK;
                        end else begin
                            nack_d  = 1'b1;
                            state_d = ST_WAIT_STOP;
                        end
                    end
                end

                ST_A_ACK: begin
                    if (scl_fall) begin
                        bit_cnt_d  = '0;
                        byte_idx_d = 1'b0;
                        if (rw_q == I2C_RD) begin
                            rd_req_d = 1'b1;
                            shreg_d  = rd_data;
                            sda_oe_d = ~rd_data[15];
                            state_d  = ST_RD_BYTE;
                        end else begin
                            sda_oe_d = 1'b0;
                            state_d  = ST_WR_BYTE;
                        end
                    end
                end

                ST_WR_BYTE: begin
                    if (scl_rise) begin
                        shreg_d   = {shreg_q[14:0], sda_s};
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end else if (scl_fall && bit_cnt_q == 4'd8) begin
                        bit_cnt_d = '0;
                        sda_oe_d  = 1'b1;
                        state_d   = ST_W_ACK;
                    end
                end

                ST_W_ACK: begin
                    if (scl_fall) begin
                        sda_oe_d = 1'b0;
                        if (is_last_byte(byte_idx_q)) begin
                            wr_data_d  = shreg_q;
                            wr_valid_d = 1'b1;
                            state_d    = ST_WAIT_STOP;
                        end else begin
                            byte_idx_d = 1'b1;
                            state_d    = ST_WR_BYTE;
                        end
                    end
                end

                ST_RD_BYTE: begin
                    if (scl_rise) begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end else if (scl_fall) begin
                        shreg_d = {shreg_q[14:0], 1'b0};
                        if (bit_cnt_q == 4'd8) begin
                            bit_cnt_d = '0;
                            sda_oe_d  = 1'b0;
                            state_d   = ST_M_ACK;
                        end else begin
                            sda_oe_d = ~shreg_q[14];
                        end
                    end
                end

                // The master's ACK/NACK does not alter a fixed-length frame, so it is not stored.
                ST_M_ACK: begin
                    if (scl_fall) begin
                        if (is_last_byte(byte_idx_q)) begin
                            state_d = ST_WAIT_STOP;
                        end else begin
                            byte_idx_d = 1'b1;
                            sda_oe_d   = ~shreg_q[15];
                            state_d    = ST_RD_BYTE;
                        end
                    end
                end

                ST_WAIT_STOP: sda_oe_d = 1'b0;

                default: state_d = ST_IDLE;
            endcase
        end
    end

    assign sda       = sda_oe_q ? 1'b0 : 1'bz;
    assign wr_data   = wr_data_q;
    assign wr_valid  = wr_valid_q;
    assign rd_req    = rd_req_q;
    assign nack_addr = nack_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_i2c_slave_rx.sv
// Directed bench for i2c_slave_rx: table of bus frames plus hand-written reset and glitch sequences.
module tb_i2c_slave_rx;

    localparam int Q = 10;  // clk cycles per quarter scl period

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        scl = 1'b1;
    logic        m_sda_low = 1'b0;
    logic [15:0] rd_data = '0;
    logic        rd_req;
    logic [15:0] wr_data;
    logic        wr_valid;
    logic        busy;
    logic        nack_addr;
    wire         sda;

    pullup (sda);
    assign sda = m_sda_low ? 1'b0 : 1'bz;

    always #5 clk = ~clk;

    i2c_slave_rx dut (
        .clk       (clk),
        .rst       (rst),
        .sclk      (scl),
        .sda       (sda),
        .rd_data   (rd_data),
        .rd_req    (rd_req),
        .wr_data   (wr_data),
        .wr_valid  (wr_valid),
        .busy      (busy),
        .nack_addr (nack_addr)
    );

    int wv_cnt = 0;
    int rr_cnt = 0;
    int nk_cnt = 0;
    int both_cnt = 0;

    always @(negedge clk) begin
        if (wr_valid)              wv_cnt++;
        if (rd_req)                rr_cnt++;
        if (nack_addr)             nk_cnt++;
        if (wr_valid && nack_addr) both_cnt++;
    end

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        string       name;
        logic [7:0]  addr_byte;
        int          nbytes;
        logic [23:0] wbytes;      // write bytes, first byte in [23:16]
        logic [15:0] rdata;
        logic        m_ack0;      // master ACKs read byte 0
        logic        exp_addr_ack;
        logic [2:0]  exp_dack;    // expected sda level in data ACK slot i
        logic [15:0] exp_wr_data;
        int          exp_wv;
        int          exp_rr;
        int          exp_nk;
    } vec_t;

    function automatic vec_t mk(input string name, input logic [7:0] ab, input int nb,
                                input logic [23:0] wb, input logic [15:0] rd, input logic mack0,
                                input logic aack, input logic [2:0] dack, input logic [15:0] ewd,
                                input int ewv, input int err, input int enk);
        vec_t v;
        v.name = name; v.addr_byte = ab; v.nbytes = nb; v.wbytes = wb; v.rdata = rd;
        v.m_ack0 = mack0; v.exp_addr_ack = aack; v.exp_dack = dack; v.exp_wr_data = ewd;
        v.exp_wv = ewv; v.exp_rr = err; v.exp_nk = enk;
        return v;
    endfunction

    task automatic wait_q();
        repeat (Q) @(negedge clk);
    endtask

    task automatic bit_xfer(input logic b, output logic s);
        m_sda_low = ~b;
        wait_q();
        scl = 1'b1;
        wait_q();
        s = sda;
        wait_q();
        scl = 1'b0;
        wait_q();
    endtask

    task automatic i2c_start();
        m_sda_low = 1'b0;
        scl = 1'b1;
        wait_q();
        m_sda_low = 1'b1;
        wait_q();
        scl = 1'b0;
        wait_q();
    endtask

    task automatic i2c_stop();
        m_sda_low = 1'b1;
        wait_q();
        scl = 1'b1;
        wait_q();
        m_sda_low = 1'b0;
        wait_q();
        wait_q();
    endtask

    task automatic write_byte(input logic [7:0] b, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) bit_xfer(b[i], s);
        bit_xfer(1'b1, ack);
    endtask

    task automatic read_byte(input logic ack_low, output logic [7:0] b, output logic ack_lvl);
        logic s;
        b = '0;
        for (int i = 0; i < 8; i++) begin
            bit_xfer(1'b1, s);
            b = {b[6:0], s};
        end
        bit_xfer(~ack_low, ack_lvl);
    endtask

    task automatic apply(input vec_t v);
        int          wv0, rr0, nk0;
        logic        a;
        logic [7:0]  b;
        logic [15:0] rv;
        wv0 = wv_cnt; rr0 = rr_cnt; nk0 = nk_cnt;
        rv  = '0;
        rd_data = v.rdata;
        i2c_start();
        check({v.name, " busy_after_start"}, 32'(busy), 32'd1);
        write_byte(v.addr_byte, a);
        check({v.name, " addr_ack"}, 32'(a), 32'(v.exp_addr_ack));
        if (v.addr_byte[0]) begin
            for (int i = 0; i < v.nbytes; i++) begin
                read_byte((i < v.nbytes - 1) && v.m_ack0, b, a);
                rv = {rv[7:0], b};
            end
            check({v.name, " sda_released_after_bit16"}, 32'(sda), 32'd1);
            check({v.name, " read_data"}, 32'(rv), 32'(v.rdata));
        end else begin
            for (int i = 0; i < v.nbytes; i++) begin
                write_byte(v.wbytes[23 - 8*i -: 8], a);
                check($sformatf("%s data_ack%0d", v.name, i), 32'(a), 32'(v.exp_dack[i]));
            end
        end
        i2c_stop();
        repeat (10) @(negedge clk);
        check({v.name, " busy_after_stop"}, 32'(busy), 32'd0);
        check({v.name, " wr_data"}, 32'(wr_data), 32'(v.exp_wr_data));
        check({v.name, " wr_valid_pulses"}, 32'(wv_cnt - wv0), 32'(v.exp_wv));
        check({v.name, " rd_req_pulses"}, 32'(rr_cnt - rr0), 32'(v.exp_rr));
        check({v.name, " nack_addr_pulses"}, 32'(nk_cnt - nk0), 32'(v.exp_nk));
    endtask

    vec_t vecs[7];

    initial begin
        logic a;

        vecs[0] = mk("write_a53c",  8'h4E, 2, 24'hA53C00, 16'h0000, 1'b0, 1'b0, 3'b000, 16'hA53C, 1, 0, 0);
        vecs[1] = mk("read_beef",   8'h4F, 2, 24'h000000, 16'hBEEF, 1'b0, 1'b0, 3'b000, 16'hA53C, 0, 1, 0);
        vecs[2] = mk("addr_miss",   8'h4C, 1, 24'h550000, 16'h0000, 1'b0, 1'b1, 3'b001, 16'hA53C, 0, 0, 1);
        vecs[3] = mk("partial_wr",  8'h4E, 1, 24'h110000, 16'h0000, 1'b0, 1'b0, 3'b000, 16'hA53C, 0, 0, 0);
        vecs[4] = mk("write_00ff",  8'h4E, 2, 24'h00FF00, 16'h0000, 1'b0, 1'b0, 3'b000, 16'h00FF, 1, 0, 0);
        vecs[5] = mk("read_mack",   8'h4F, 2, 24'h000000, 16'h0180, 1'b1, 1'b0, 3'b000, 16'h00FF, 0, 1, 0);
        vecs[6] = mk("write_3byte", 8'h4E, 3, 24'h123456, 16'h0000, 1'b0, 1'b0, 3'b100, 16'h1234, 1, 0, 0);

        repeat (5) @(negedge clk);
        check("reset busy",      32'(busy),      32'd0);
        check("reset wr_data",   32'(wr_data),   32'd0);
        check("reset wr_valid",  32'(wr_valid),  32'd0);
        check("reset rd_req",    32'(rd_req),    32'd0);
        check("reset nack_addr", 32'(nack_addr), 32'd0);
        check("reset sda",       32'(sda),       32'd1);
        rst = 1'b1;
        repeat (10) @(negedge clk);

        for (int i = 0; i < 7; i++) apply(vecs[i]);

        // Reset while the slave drives a 0 data bit of a read frame.
        rd_data = 16'h00FF;
        i2c_start();
        write_byte(8'h4F, a);
        check("rst_mid addr_ack", 32'(a), 32'd0);
        check("rst_mid slave_drives_0", 32'(sda), 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("rst_mid sda_released", 32'(sda),  32'd1);
        check("rst_mid busy",         32'(busy), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        check("rst_mid wr_data", 32'(wr_data), 32'd0);
        i2c_stop();
        repeat (10) @(negedge clk);
        apply(mk("after_rst", 8'h4E, 2, 24'hCAFE00, 16'h0000, 1'b0, 1'b0, 3'b000, 16'hCAFE, 1, 0, 0));

`ifdef I2C_SLV_FILT_EN
        // Two-clock sda low glitch while scl is high must not look like START.
        scl = 1'b1;
        m_sda_low = 1'b0;
        repeat (10) @(negedge clk);
        m_sda_low = 1'b1;
        repeat (2) @(negedge clk);
        m_sda_low = 1'b0;
        repeat (20) @(negedge clk);
        check("glitch busy", 32'(busy), 32'd0);
`endif

        check("wr_valid_with_nack", 32'(both_cnt), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
